// File: rtl/cnn_pkg.sv
// Shared widths, packer FSM encoding and datapath helpers
// for the CNN blocks feeding the fully-connected stage.
package cnn_pkg;

  localparam int CNN_DATA_W   = 32;
  localparam int FC_NUM_WORDS = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_FILL    = 2'd0;
  localparam state_t ST_FIRE    = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  // Pure compare, so the most negative value needs no care.
  function automatic logic [CNN_DATA_W-1:0] smax(
    input logic [CNN_DATA_W-1:0] a,
    input logic [CNN_DATA_W-1:0] b
  );
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/fc_input_packer_if.sv
// Sample stream in, packed frame plus enable/done out, for the
// FC input packer; master drives samples and done.
interface fc_input_packer_if
  import cnn_pkg::*;
#(
  parameter int DATA_W    = CNN_DATA_W,
  parameter int NUM_WORDS = FC_NUM_WORDS
);

  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_W-1:0]           in_data;
  logic [DATA_W*NUM_WORDS-1:0] fc_input;
  logic                        fc_enable;
  logic                        fc_done;

  modport master (
    output in_valid,
    output in_data,
    output fc_done,
    input  in_ready,
    input  fc_input,
    input  fc_enable
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  fc_done,
    output in_ready,
    output fc_input,
    output fc_enable
  );

endinterface

// File: rtl/maxpool_window.sv
// Running signed max over POOL accepted samples; pulses
// word_valid with the window result on the last sample.
module maxpool_window
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int POOL   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [DATA_W-1:0] sample,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int CW = (POOL > 1) ? $clog2(POOL) : 1;

  logic [CW-1:0]     pool_cnt;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] combined;
  logic              last;

  always_comb begin
`ifdef FC_PACKER_RELU_EN
    x = sample[DATA_W-1] ? '0 : sample;
`else
    x = sample;
`endif
    combined = (pool_cnt == '0) ? x : smax(max_q, x);
  end

  assign last       = (pool_cnt == CW'(POOL - 1));
  assign word_valid = accept && last;
  assign word       = combined;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pool_cnt <= '0;
      max_q    <= '0;
    end else if (accept) begin
      max_q    <= combined;
      pool_cnt <= last ? '0 : pool_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fc_input_packer.sv
// Max-pools the sample stream into NUM_WORDS words and hands the frame
// to the FC stage. FC_PACKER_RELU_EN clamps negative samples to 0.
module fc_input_packer
  import cnn_pkg::*;
#(
  parameter int DATA_W    = CNN_DATA_W,
  parameter int NUM_WORDS = FC_NUM_WORDS,
  parameter int POOL      = 2
) (
  input  logic                clk,
  input  logic                rst,
  fc_input_packer_if.slave    bus,
  output logic [15:0]         frame_cnt
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_t                      state_q;
  logic [IW-1:0]               word_idx_q;
  logic [DATA_W*NUM_WORDS-1:0] frame_q;
  logic                        enable_q;
  logic [15:0]                 frame_cnt_q;
  logic                        accept;
  logic                        word_valid;
  logic [DATA_W-1:0]           word;

  assign bus.in_ready  = (state_q == ST_FILL);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.fc_input  = frame_q;
  assign bus.fc_enable = enable_q;
  assign frame_cnt     = frame_cnt_q;

  maxpool_window #(
    .DATA_W (DATA_W),
    .POOL   (POOL)
  ) u_pool (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .sample     (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      word_idx_q  <= '0;
      frame_q     <= '0;
      enable_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      unique case (1'b1)
        (state_q == ST_FILL): begin
          if (word_valid) begin
            frame_q[word_idx_q*DATA_W +: DATA_W] <= word;
            if (word_idx_q == IW'(NUM_WORDS - 1)) begin
              word_idx_q <= '0;
              enable_q   <= 1'b1;
              state_q    <= ST_FIRE;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
            end
          end
        end
        (state_q == ST_FIRE): begin
          if (bus.fc_done) begin
            enable_q    <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= ST_RELEASE;
          end
        end
        // One dead cycle so the FC stage sees enable low between frames.
        (state_q == ST_RELEASE): state_q <= ST_FILL;
        default: state_q <= ST_FILL;
      endcase
    end
  end

endmodule

// File: doc/fc_input_packer.md
Name: fc_input_packer

Overview:
- Upstream neighbour of the fully-connected stage.
- Accepts a stream of signed 32-bit conv/activation samples and applies 1-D max pooling over POOL consecutive samples.
- Packs NUM_WORDS pooled words into one flat vector, then drives the FC stage's fc_input/enable and waits for its done.
- Blocks new input while the FC stage consumes the vector.

Parameters:
- DATA_W, 32, width of each signed sample/pooled word.
- NUM_WORDS, 8, pooled words per FC frame (fc_input width = DATA_W*NUM_WORDS).
- POOL, 2, samples per max-pool window (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  packer can accept a sample.
- in_data  input  DATA_W  signed sample.
- fc_input  output  DATA_W*NUM_WORDS  packed frame; word k at bits [k*DATA_W +: DATA_W].
- fc_enable  output  1  frame valid, held until fc_done.
- fc_done  input  1  FC stage finished with frame.
- frame_cnt  output  16  count of frames handed off, wraps 0xFFFF->0.

Behaviour:
- Reset (rst=0, async): state=FILL, pool_cnt=0, word_idx=0, running max=0, fc_input=0, fc_enable=0, frame_cnt=0. in_ready is combinational and equals 1 in FILL, so it is 1 during reset.
- Transfer: a sample is accepted on a rising edge where in_valid && in_ready.
- States: FILL, FIRE, RELEASE.
- FILL:
  - in_ready=1.
  - Accept with pool_cnt==0: load max <= sample unconditionally.
  - Accept with pool_cnt>0: max <= signed max(max, sample).
  - Accept with pool_cnt==POOL-1: write the window result (max combined with this sample) into word[word_idx], pool_cnt<=0, word_idx++.
  - Otherwise on accept: pool_cnt++.
  - Writing word NUM_WORDS-1: word_idx<=0 and next state FIRE.
  - POOL=1 means each sample is written directly.
- FIRE:
  - in_ready=0; fc_enable=1 (registered, high the cycle after the final accept).
  - fc_input held stable.
  - On fc_done=1: fc_enable<=0, frame_cnt++, go RELEASE.
- RELEASE:
  - in_ready=0, fc_enable=0; one cycle, then FILL.
  - Guarantees the FC stage sees enable low at least one cycle between frames.
- fc_input is not cleared between frames. Words are overwritten in place during the next FILL.
- Latency: final accept edge N -> fc_enable=1 after edge N. fc_done sampled high at edge M -> fc_enable=0 and frame_cnt updated after M. in_ready=1 again after M+1.
- Boundaries:
  - fc_done high in FILL or RELEASE: ignored.
  - fc_done already high when FIRE is entered: honoured on the first FIRE edge, giving a minimum 1-cycle enable.
  - in_valid during FIRE/RELEASE: not accepted; upstream holds data.
  - Signed compare: the most negative value is handled correctly, with no overflow (compare only).
  - Reset mid-FILL/FIRE: partial frame discarded, all state returns to reset values.

Optional Feature:
- Macro: FC_PACKER_RELU_EN.
- Defined: each accepted sample is clamped to 0 if negative before pooling, so all pooled words are >=0.
- Undefined: raw signed samples are pooled.
- Port list is identical either way.

Decomposition:
- Shared package cnn_pkg:
  - DATA_W default.
  - FC_NUM_WORDS.
  - State encoding typedef (FILL/FIRE/RELEASE).
  - A signed-max function.
- One natural sub-module, maxpool_window: owns pool_cnt and the running max, and emits a word_valid/word pulse.
- The packer top owns word_idx, the frame register and the FC handshake FSM.

Test Plan:
- Defaults, RELU off, stream 5,-3 -> word0=5; stream -7,-2 -> word1=-2 (0xFFFFFFFE).
- RELU on, same -7,-2 window -> word1=0; sample 0x80000000 paired with 1 -> 1.
- Back-to-back 16 valid samples 1..16 -> fc_enable=1 the cycle after the 16th accept; fc_input words = 2,4,6,...,16 (word0 in LSBs); in_ready=0.
- In FIRE, hold fc_done=0 for 5 cycles with in_valid=1 -> no accepts, fc_input unchanged. Then fc_done=1 -> fc_enable=0 and frame_cnt=1 next cycle; in_ready=1 one cycle later.
- Assert rst=0 after 7 samples of a frame -> outputs reset immediately. After release, 16 new samples produce a full correct frame and frame_cnt=1.
- fc_done held permanently high -> each frame gets exactly a 1-cycle fc_enable pulse. After 65536 frames (forced counter preload acceptable), frame_cnt wraps to 0.
